// File: rtl/game_pkg.sv
// Shared encodings for the typing-game sequencer: phase states, key scancodes
// and the round option tables.
package game_pkg;

   typedef enum logic [1:0] {
      ST_SELECT    = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_INGAME    = 2'd2,
      ST_FINISH    = 2'd3
   } game_state_e;

   localparam logic [6:0] KEY_ENTER = 7'd90;
   localparam logic [6:0] KEY_ESC   = 7'd118;
   localparam logic [6:0] KEY_TAB   = 7'd13;
   localparam logic [6:0] KEY_A     = 7'd28;
   localparam logic [6:0] KEY_D     = 7'd35;
   localparam logic [6:0] KEY_SPACE = 7'd41;
   localparam logic [6:0] KEY_BACK  = 7'd102;

   // Entry [0] is the leftmost option in the menu.
   localparam logic [3:0][6:0] TIME_OPTS = {7'd120, 7'd60, 7'd30, 7'd15};
   localparam logic [3:0][6:0] WORD_OPTS = {7'd100, 7'd50, 7'd25, 7'd10};

   function automatic logic [6:0] opt_value(input logic mode, input logic [1:0] sel);
      return mode ? WORD_OPTS[sel] : TIME_OPTS[sel];
   endfunction

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1), seed 1; never reaches zero.
module lfsr10 (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] q
);

   logic [9:0] lfsr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 10'h001;
      else     lfsr_q <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[9:1]};
   end

   assign q = lfsr_q;

endmodule

// File: rtl/game_ctrl.sv
// Typing-game sequencer: menu selection from key presses, then the
// SELECT -> COUNTDOWN -> INGAME -> FINISH round flow.
module game_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_down,
   input  logic [8:0]   last_change,
   input  logic         key_valid,
   input  logic         finish,
   output logic [1:0]   state,
   output logic         mode,
   output logic [6:0]   value,
   output logic [1:0]   cd_digit,
   output logic [9:0]   random_id
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   game_state_e   state_q, state_d;
   logic          mode_q, mode_d;
   logic [1:0]    sel_q, sel_d;
   logic [6:0]    value_q, value_d;
   logic [1:0]    cd_q, cd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [127:0]  prev_q;

   logic [6:0] code;
   logic       press;
   logic       tick;

   // A press needs the key down now but not on the previous cycle, which
   // filters typematic repeats; codes >= 128 (extended) are dropped.
   assign code  = last_change[6:0];
   assign press = key_valid && (last_change[8:7] == 2'b00)
                  && key_down[code] && !prev_q[code];
   assign tick  = (cnt_q == TICK_LAST);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sel_d   = sel_q;
      cd_d    = cd_q;
      cnt_d   = '0;
      case (state_q)
         ST_SELECT: begin
            if (press && code == KEY_ENTER) begin
               state_d = ST_COUNTDOWN;
               cd_d    = 2'd3;
            end else if (press && code == KEY_TAB) begin
               mode_d = ~mode_q;
            end else if (press && code == KEY_A && sel_q != 2'd0) begin
               sel_d = sel_q - 2'd1;
            end else if (press && code == KEY_D && sel_q != 2'd3) begin
               sel_d = sel_q + 2'd1;
            end
         end
         ST_COUNTDOWN: begin
            if (press && code == KEY_ESC) begin
               state_d = ST_SELECT;
               cd_d    = 2'd0;
            end else if (tick) begin
               if (cd_q == 2'd1) begin
                  state_d = ST_INGAME;
                  cd_d    = 2'd0;
               end else begin
                  cd_d = cd_q - 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_INGAME: begin
            if (press && code == KEY_ESC) state_d = ST_SELECT;
            else if (finish)              state_d = ST_FINISH;
         end
         ST_FINISH: begin
            if (press && (code == KEY_ENTER || code == KEY_ESC)) state_d = ST_SELECT;
         end
         default: state_d = ST_SELECT;
      endcase
      value_d = opt_value(mode_d, sel_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SELECT;
         mode_q  <= 1'b0;
         sel_q   <= 2'd1;
         value_q <= 7'd30;
         cd_q    <= 2'd0;
         cnt_q   <= '0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sel_q   <= sel_d;
         value_q <= value_d;
         cd_q    <= cd_d;
         cnt_q   <= cnt_d;
         prev_q  <= key_down;
      end
   end

   lfsr10 u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (random_id)
   );

   assign state    = state_q;
   assign mode     = mode_q;
   assign value    = value_q;
   assign cd_digit = cd_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: menu navigation, countdown timing, round
// flow, typematic filtering and asynchronous reset.
module tb_game_ctrl;

   localparam int TD = 10;
   localparam logic [6:0] K_ENTER = 7'd90;
   localparam logic [6:0] K_ESC   = 7'd118;
   localparam logic [6:0] K_TAB   = 7'd13;
   localparam logic [6:0] K_A     = 7'd28;
   localparam logic [6:0] K_D     = 7'd35;

   logic         clk;
   logic         rst;
   logic [127:0] key_down;
   logic [8:0]   last_change;
   logic         key_valid;
   logic         finish;
   logic [1:0]   state;
   logic         mode;
   logic [6:0]   value;
   logic [1:0]   cd_digit;
   logic [9:0]   random_id;

   int n_assert = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];

   game_ctrl #(.TICK_DIV(TD)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_down    (key_down),
      .last_change (last_change),
      .key_valid   (key_valid),
      .finish      (finish),
      .state       (state),
      .mode        (mode),
      .value       (value),
      .cd_digit    (cd_digit),
      .random_id   (random_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One-cycle make event, then the key is released on the following cycle.
   task automatic press(input logic [6:0] k);
      key_down[k] = 1'b1;
      last_change = {2'b00, k};
      key_valid   = 1'b1;
      @(negedge clk);
      key_valid   = 1'b0;
      key_down[k] = 1'b0;
      @(negedge clk);
   endtask

   // ENTER from SELECT, then check cd_digit/state for samples 0..last_k after the edge.
   task automatic run_countdown(input int last_k, input int fin_at);
      int exp_cd;
      int exp_st;
      key_down[K_ENTER] = 1'b1;
      last_change       = {2'b00, K_ENTER};
      key_valid         = 1'b1;
      @(negedge clk);
      key_valid         = 1'b0;
      key_down[K_ENTER] = 1'b0;
      for (int k = 0; k <= last_k; k++) begin
         exp_cd = (k < TD) ? 3 : (k < 2*TD) ? 2 : (k < 3*TD) ? 1 : 0;
         exp_st = (k < 3*TD) ? 1 : 2;
         chk($sformatf("cd_k%0d", k), cd_digit, exp_cd);
         chk($sformatf("st_k%0d", k), state, exp_st);
         finish = (k == fin_at);
         if (k < last_k) @(negedge clk);
      end
      finish = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      key_down    = '0;
      last_change = '0;
      key_valid   = 1'b0;
      finish      = 1'b0;

      // Reset state and LFSR start
      @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_value", value, 30);
      rst = 1'b0;
      exp_q.push_back(10'h001);
      exp_q.push_back(10'h200);
      exp_q.push_back(10'h100);
      while (exp_q.size() > 0) begin
         chk("lfsr_seq", random_id, exp_q.pop_front());
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("idle_state", state, 0);
      chk("idle_mode", mode, 0);
      chk("idle_value", value, 30);
      chk("idle_cd", cd_digit, 0);

      // Menu navigation
      press(K_D);
      chk("d1_value", value, 60);
      press(K_D);
      press(K_D);
      chk("d3_value", value, 120);
      press(K_TAB);
      chk("tab_value", value, 100);
      chk("tab_mode", mode, 1);
      repeat (5) press(K_A);
      chk("a5_value", value, 10);

      // finish ignored in SELECT
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      chk("fin_sel_state", state, 0);

      // Held D with repeated key_valid: one step only
      key_down[K_D] = 1'b1;
      repeat (4) begin
         last_change = {2'b00, K_D};
         key_valid   = 1'b1;
         @(negedge clk);
         key_valid   = 1'b0;
         @(negedge clk);
      end
      chk("hold_value", value, 25);
      key_down[K_D] = 1'b0;
      key_valid     = 1'b1;
      @(negedge clk);
      key_valid     = 1'b0;
      chk("release_value", value, 25);

      // Full countdown with finish injected mid-countdown
      run_countdown(3*TD, 5);
      chk("ingame_value", value, 25);

      press(K_TAB);
      chk("ig_tab_mode", mode, 1);
      chk("ig_tab_state", state, 2);

      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      chk("finish_state", state, 3);
      press(K_ENTER);
      chk("fin_enter_state", state, 0);

      // ESC beats finish in INGAME
      run_countdown(3*TD, -1);
      key_down[K_ESC] = 1'b1;
      last_change     = {2'b00, K_ESC};
      key_valid       = 1'b1;
      finish          = 1'b1;
      @(negedge clk);
      key_valid       = 1'b0;
      key_down[K_ESC] = 1'b0;
      finish          = 1'b0;
      chk("esc_fin_state", state, 0);

      // Asynchronous reset mid-countdown
      run_countdown(12, -1);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", state, 0);
      chk("arst_mode", mode, 0);
      chk("arst_value", value, 30);
      chk("arst_cd", cd_digit, 0);
      chk("arst_lfsr", random_id, 10'h001);
      @(negedge clk);
      rst = 1'b0;
      run_countdown(TD, -1);

      // ESC during countdown
      press(K_ESC);
      chk("cd_esc_state", state, 0);
      chk("cd_esc_cd", cd_digit, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the typing game. It turns keyboard make events into menu selections and drives the four-phase game flow: SELECT, COUNTDOWN, INGAME, FINISH. It sits directly upstream of the word/score counter and supplies that counter's `state`, `mode`, `value` and `random_id` inputs. It consumes the counter's `finish` flag to end a round.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per countdown second; benches use a small value such as 10.
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_down`  in  128  per-scancode held flags from the keyboard decoder.
- `last_change`  in  9  scancode of the most recent keyboard event.
- `key_valid`  in  1  one-cycle pulse that qualifies `last_change`.
- `finish`  in  1  round-complete flag from the counter; used only in INGAME.
- `state`  out  2  SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
- `mode`  out  1  0 = timed round, 1 = word-count round.
- `value`  out  7  time limit in seconds (mode 0) or word target (mode 1).
- `cd_digit`  out  2  countdown digit to display: 3, 2 or 1 in COUNTDOWN, else 0.
- `random_id`  out  10  pseudo-random word id; never 0.

## Operation
- Press event: `key_valid` = 1, `last_change` < 128, `key_down[last_change]` = 1, and the registered previous-cycle copy of `key_down[last_change]` = 0. This suppresses typematic repeats. Releases and extended codes (≥128) are ignored.
- Key codes: ENTER = 90, ESC = 118, TAB = 13, A = 28, D = 35.
- Option tables, indexed by 2-bit `sel`:
  - mode 0: {15, 30, 60, 120}
  - mode 1: {10, 25, 50, 100}
  - `value` = table[mode][sel].
- SELECT:
  - TAB toggles `mode`; `sel` is kept.
  - A decrements `sel`, saturating at 0; D increments `sel`, saturating at 3.
  - ENTER moves to COUNTDOWN; `cd_digit` ← 3 and the tick counter ← 0.
- COUNTDOWN:
  - The tick counter counts 0..TICK_DIV−1; a wrap is a tick.
  - On each tick `cd_digit` decrements. A tick while `cd_digit` = 1 moves to INGAME and sets `cd_digit` ← 0.
  - ESC moves to SELECT.
  - `mode`, `sel` and `value` are frozen in every state except SELECT.
- INGAME:
  - `finish` = 1 moves to FINISH.
  - ESC moves to SELECT.
  - ESC wins if both occur in the same cycle.
- FINISH: ENTER or ESC moves to SELECT.
- `finish` is ignored outside INGAME. Keys not listed for a state are ignored.
- `random_id`: 10-bit Fibonacci LFSR, polynomial x^10+x^7+1, shifted every clk in all states, seed 10'h001. Period is 1023 and the all-zero state is unreachable.

## Timing
- Reset values: `state` = SELECT, `mode` = 0, `sel` = 1 (so `value` = 30), `cd_digit` = 0, `random_id` = 10'h001, tick counter = 0, previous-key register = 0.
- All outputs are registered.
- A press event in cycle N takes effect on the edge ending cycle N; the new output is visible in cycle N+1.
- COUNTDOWN entered at edge E:
  - `cd_digit` = 3 until E + TICK_DIV, then 2 until E + 2·TICK_DIV, then 1.
  - At E + 3·TICK_DIV: `state` = INGAME and `cd_digit` = 0.
- ESC during COUNTDOWN clears the tick counter and `cd_digit` on the same edge. Re-entry always gives a full 3 s.
- `finish` asserted in cycle N gives `state` = FINISH in cycle N+1.
- Reset mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.
- The LFSR value is never held or reloaded except by `rst`.

## Structure
- Package `game_pkg`:
  - state encodings
  - key codes ENTER / ESC / TAB / A / D / SPACE / BACK
  - the two 4-entry option tables
- Sub-module `lfsr10`:
  - ports: `clk`, `rst`, output `q[9:0]`
  - free-running, seed 1
  - instantiated once here
- The press-edge detector, the FSM and the tick counter stay in `game_ctrl`.

## Test plan
- Reset, then idle 5 cycles → `state` = 0, `mode` = 0, `value` = 30, `cd_digit` = 0, `random_id` sequence starts 001, 200, 100.
- In SELECT press D, D, D (`sel` saturates at 3) → `value` = 120; TAB → `value` = 100, `mode` = 1; A ×5 → `value` = 10.
- TICK_DIV = 10, ENTER → `cd_digit` 3/2/1 for exactly 10 cycles each; `state` = 2 exactly 30 cycles after the ENTER edge, with `cd_digit` = 0.
- INGAME: assert `finish` one cycle → `state` = 3 next cycle; `finish` in SELECT/COUNTDOWN → no change; ESC and `finish` in the same INGAME cycle → `state` = 0.
- Hold D with 4 repeated `key_valid` pulses and no intervening release → `value` advances one option only; TAB during INGAME → `mode` unchanged.
- Assert `rst` mid-COUNTDOWN (`cd_digit` = 2) → all outputs at reset values before the next clk edge; ENTER afterwards → full countdown from 3.
